countdown_timer: RTL and testbench

Registered N-bit down-counting timer with load, start/pause control, a tick-enable input and a terminal-count flag. It is the sequential user of the down-count direction of the team's N-bit incrementer/decrementer: it holds the count in flops, decrements on each qualified tick, and reports expiry. It sits between a prescaler that produces `tick` strobes (e.g. 1 Hz) and the display/alarm logic of the lab clock.

---
 rtl/countdown_timer.sv | 103 ++++++++++
 tb/tb_countdown_timer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Registered N-bit down-counting timer with load, start/pause control,
// tick enable, optional auto-reload and a one-cycle expiry pulse.
module countdown_timer #(
  parameter int N           = 8,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  input  logic         tick,
  output logic [N-1:0] count,
  output logic         running,
  output logic         done,
  output logic         expire
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [N-1:0] count_nxt;
  logic [N-1:0] reload, reload_nxt;
  logic         expire_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      expire <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      expire <= expire_nxt;
    end
  end

  // Strobes a state ignores never mask a lower-priority strobe it does act on.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    expire_nxt = 1'b0;
    if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              state_nxt = RUN;
            end else begin
              state_nxt  = DONE;
              expire_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_nxt = PAUSED;
          end else if (tick) begin
            if (count > ONE) begin
              count_nxt = count - ONE;
            end else begin
              expire_nxt = 1'b1;
              if (AUTO_RELOAD && (reload != '0)) begin
                count_nxt = reload;
              end else begin
                count_nxt = '0;
                state_nxt = DONE;
              end
            end
          end
        end
        PAUSED: begin
          if (start) state_nxt = RUN;
        end
        DONE: begin
          if (start) begin
            if (reload != '0) begin
              count_nxt = reload;
              state_nxt = RUN;
            end else begin
              expire_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: two timers (one-shot and auto-reload) share stimulus; a
// behavioural model queues expected outputs, a monitor pops and compares.
module tb_countdown_timer;

  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_DONE} mode_t;
  typedef struct packed {
    logic [7:0] c;
    logic       r;
    logic       d;
    logic       e;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] count0, count1;
  logic       running0, running1, done0, done1, expire0, expire1;

  int tests = 0;
  int errors = 0;

  obs_t  exp_q0[$];
  obs_t  exp_q1[$];
  mode_t m_mode[2];
  int    m_count[2];
  int    m_reload[2];

  countdown_timer #(.N(8), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .tick(tick),
    .count(count0), .running(running0), .done(done0), .expire(expire0)
  );

  countdown_timer #(.N(8), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .start(start), .pause(pause), .tick(tick),
    .count(count1), .running(running1), .done(done1), .expire(expire1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k]   = M_IDLE;
      m_count[k]  = 0;
      m_reload[k] = 0;
    end
  endtask

  // Reference behaviour: what the timer shows one cycle after these strobes.
  task automatic modelStep(input int k, input bit ar, input bit ld, input int lv,
                           input bit st, input bit pa, input bit tk);
    bit   e;
    obs_t o;
    e = 1'b0;
    if (ld) begin
      m_count[k]  = lv;
      m_reload[k] = lv;
      m_mode[k]   = M_IDLE;
    end else begin
      case (m_mode[k])
        M_IDLE:
          if (st) begin
            if (m_count[k] != 0) m_mode[k] = M_RUN;
            else begin
              m_mode[k] = M_DONE;
              e = 1'b1;
            end
          end
        M_RUN:
          if (pa) m_mode[k] = M_PAUSED;
          else if (tk) begin
            if (m_count[k] > 1) m_count[k] = m_count[k] - 1;
            else begin
              e = 1'b1;
              if (ar && m_reload[k] != 0) m_count[k] = m_reload[k];
              else begin
                m_count[k] = 0;
                m_mode[k]  = M_DONE;
              end
            end
          end
        M_PAUSED:
          if (st) m_mode[k] = M_RUN;
        M_DONE:
          if (st) begin
            if (m_reload[k] != 0) begin
              m_count[k] = m_reload[k];
              m_mode[k]  = M_RUN;
            end else e = 1'b1;
          end
        default: m_mode[k] = M_IDLE;
      endcase
    end
    o.c = 8'(m_count[k]);
    o.r = (m_mode[k] == M_RUN);
    o.d = (m_mode[k] == M_DONE);
    o.e = e;
    if (k == 0) exp_q0.push_back(o);
    else        exp_q1.push_back(o);
  endtask

  task automatic applyStimulus(input bit ld, input int lv, input bit st,
                               input bit pa, input bit tk);
    @(negedge clk);
    load     = ld;
    load_val = 8'(lv);
    start    = st;
    pause    = pa;
    tick     = tk;
    modelStep(0, 1'b0, ld, lv, st, pa, tk);
    modelStep(1, 1'b1, ld, lv, st, pa, tk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 1);
  endtask

  // Waits until the monitor has consumed every queued expectation.
  task automatic drain();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        checkOutput("ar0 count", int'(count0), int'(e.c));
        checkOutput("ar0 running", int'(running0), int'(e.r));
        checkOutput("ar0 done", int'(done0), int'(e.d));
        checkOutput("ar0 expire", int'(expire0), int'(e.e));
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        checkOutput("ar1 count", int'(count1), int'(e.c));
        checkOutput("ar1 running", int'(running1), int'(e.r));
        checkOutput("ar1 done", int'(done1), int'(e.d));
        checkOutput("ar1 expire", int'(expire1), int'(e.e));
      end
    end
  end

  initial begin : stimulus
    int r, sel, lv;
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset count", int'(count0), 0);
    checkOutput("reset running", int'(running0), 0);
    checkOutput("reset done", int'(done0), 0);
    checkOutput("reset expire", int'(expire0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(5);

    // Basic countdown, then further ticks and a restart from DONE
    applyStimulus(1, 3, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    ticks(3);
    ticks(2);
    drain();
    checkOutput("countdown done", int'(done0), 1);
    applyStimulus(0, 0, 1, 0, 0);
    drain();
    checkOutput("restart count", int'(count0), 3);
    checkOutput("restart running", int'(running0), 1);

    // Pause with a same-cycle tick, ignored ticks, resume
    applyStimulus(1, 5, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    ticks(2);
    applyStimulus(0, 0, 0, 1, 1);
    ticks(3);
    applyStimulus(0, 0, 1, 0, 0);
    ticks(1);
    drain();
    checkOutput("resume count", int'(count0), 2);

    // Auto-reload sequence (one-shot instance expires on the second tick)
    applyStimulus(1, 2, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    ticks(6);

    // Start at zero, then held start in DONE with reload 0
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    idleCycles(1);

    // Load beats a tick at count 1
    applyStimulus(1, 3, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    ticks(2);
    applyStimulus(1, 6, 0, 0, 1);
    idleCycles(2);

    // Asynchronous reset mid-run at count 7
    applyStimulus(1, 9, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    ticks(2);
    drain();
    checkOutput("pre-reset count", int'(count0), 7);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset count", int'(count0), 0);
    checkOutput("async reset running", int'(running0), 0);
    checkOutput("async reset done", int'(done0), 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2);

    // Randomized traffic; start and pause never share a cycle
    for (int i = 0; i < 1500; i++) begin
      r   = $urandom_range(0, 99);
      sel = $urandom_range(0, 9);
      lv  = ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 12);
      applyStimulus(r < 5, lv, sel < 2, sel == 2, $urandom_range(0, 1) == 1);
    end

    drain();
    checkOutput("scoreboard drained", exp_q0.size() + exp_q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
